// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the basic-gate sweep checker and its
// golden truth-table helper.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned NVEC     = 4;
    localparam int unsigned SETTLE_W = 4;

    typedef logic [1:0]          vec_idx_t;
    typedef logic [SETTLE_W-1:0] settle_t;

    localparam vec_idx_t LAST_IDX = vec_idx_t'(NVEC - 1);

endpackage

// File: rtl/gate_sweep_golden.sv
// Golden AND/OR/NOT truth table for a two-input vector {a,b}; purely
// combinational so any checker can share one definition.
module gate_sweep_golden
    import gate_sweep_pkg::*;
(
    input  vec_idx_t vec_i,
    output logic     exp_and_o,
    output logic     exp_or_o,
    output logic     exp_not_o
);

    logic a;
    logic b;

    assign a = vec_i[1];
    assign b = vec_i[0];

    assign exp_and_o = a & b;
    assign exp_or_o  = a | b;
    assign exp_not_o = ~a;

endmodule

// File: rtl/gate_sweep_checker.sv
// Sequencer that walks the gate block through 00,01,10,11, samples its
// outputs after a settle delay and records error count and first failure.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             g_and_i,
    input  logic             g_or_i,
    input  logic             g_not_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [1:0]       fail_idx
);

    localparam settle_t SETTLE_C = settle_t'(SETTLE);

    state_e             state_q,     state_d;
    vec_idx_t           idx_q,       idx_d;
    settle_t            cnt_q,       cnt_d;
    logic [ERR_W-1:0]   err_q,       err_d;
    logic               fail_seen_q, fail_seen_d;
    vec_idx_t           fail_idx_q,  fail_idx_d;
    logic               a_q,         a_d;
    logic               b_q,         b_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;

    logic exp_and;
    logic exp_or;
    logic exp_not;
    logic vec_fail;
    logic sample;

    gate_sweep_golden u_golden (
        .vec_i     (idx_q),
        .exp_and_o (exp_and),
        .exp_or_o  (exp_or),
        .exp_not_o (exp_not)
    );

    assign vec_fail = (g_and_i != exp_and) | (g_or_i != exp_or) | (g_not_i != exp_not);
    assign sample   = (cnt_q == SETTLE_C);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        fail_idx_d  = fail_idx_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    idx_d       = '0;
                    cnt_d       = '0;
                    err_d       = '0;
                    fail_seen_d = 1'b0;
                    fail_idx_d  = '0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end

            DRIVE: begin
                if (sample) begin
                    cnt_d = '0;
                    if (vec_fail) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            fail_idx_d  = idx_q;
                        end
                    end
                    // pass must reflect the compare made on this same edge
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d        = idx_q + 1'b1;
                        {a_d, b_d}   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            fail_idx_q  <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            fail_idx_q  <= fail_idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_seen = fail_seen_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: behavioural gate model with
// selectable faults, SETTLE=2 main instance and a SETTLE=0 instance.
module tb_gate_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start0;
    int         mode;       // 0 correct, 1 AND/OR swapped, 2 NOT stuck at 0

    logic       a_o, b_o, g_and, g_or, g_not;
    logic       busy, done, pass, fail_seen;
    logic [2:0] err_cnt;
    logic [1:0] fail_idx;

    logic       a0_o, b0_o, g0_and, g0_or, g0_not;
    logic       busy0, done0, pass0, fail_seen0;
    logic [2:0] err_cnt0;
    logic [1:0] fail_idx0;

    int n_vec = 0;
    int n_mis = 0;

    gate_sweep_checker #(.SETTLE(2), .ERR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_o       (a_o),
        .b_o       (b_o),
        .g_and_i   (g_and),
        .g_or_i    (g_or),
        .g_not_i   (g_not),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_seen (fail_seen),
        .fail_idx  (fail_idx)
    );

    gate_sweep_checker #(.SETTLE(0), .ERR_W(3)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .a_o       (a0_o),
        .b_o       (b0_o),
        .g_and_i   (g0_and),
        .g_or_i    (g0_or),
        .g_not_i   (g0_not),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .err_cnt   (err_cnt0),
        .fail_seen (fail_seen0),
        .fail_idx  (fail_idx0)
    );

    always_comb begin
        g_and = (mode == 1) ? (a_o | b_o) : (a_o & b_o);
        g_or  = (mode == 1) ? (a_o & b_o) : (a_o | b_o);
        g_not = (mode == 2) ? 1'b0 : ~a_o;
    end

    assign g0_and = a0_o & b0_o;
    assign g0_or  = a0_o | b0_o;
    assign g0_not = ~a0_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a"},    32'(a_o),       0);
        chk({tag, ".b"},    32'(b_o),       0);
        chk({tag, ".busy"}, 32'(busy),      0);
        chk({tag, ".done"}, 32'(done),      0);
        chk({tag, ".pass"}, 32'(pass),      0);
        chk({tag, ".err"},  32'(err_cnt),   0);
        chk({tag, ".fs"},   32'(fail_seen), 0);
        chk({tag, ".fi"},   32'(fail_idx),  0);
    endtask

    // Full SETTLE=2 sweep from edge 0; repulse>0 raises start again in that cycle.
    task automatic run_sweep(input int repulse);
        int exp_ab;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("clr.err",  32'(err_cnt),   0);
        chk("clr.fs",   32'(fail_seen), 0);
        chk("clr.pass", 32'(pass),      0);
        for (int c = 1; c <= 13; c++) begin
            exp_ab = (c <= 12) ? (c - 1) / 3 : 3;
            chk($sformatf("ab@%0d", c),   32'({a_o, b_o}), 32'(exp_ab));
            chk($sformatf("busy@%0d", c), 32'(busy),       32'(c <= 12));
            chk($sformatf("done@%0d", c), 32'(done),       32'(c == 13));
            start = (c == repulse);
            if (c < 13) tick(1);
        end
        start = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        mode   = 0;
        tick(2);
        chk_all_zero("reset");
        chk("reset.busy0", 32'(busy0), 0);
        rst = 1'b0;
        tick(1);

        // clean sweep
        run_sweep(0);
        chk("ok.pass", 32'(pass),      1);
        chk("ok.err",  32'(err_cnt),   0);
        chk("ok.fs",   32'(fail_seen), 0);
        tick(2);
        chk("ok.hold", 32'({done, a_o, b_o}), 32'b111);

        // start while busy is ignored
        run_sweep(6);
        chk("rep.pass", 32'(pass), 1);

        // AND/OR swapped: vectors 1 and 2 fail
        mode = 1;
        run_sweep(0);
        chk("swap.err",  32'(err_cnt),   2);
        chk("swap.fi",   32'(fail_idx),  1);
        chk("swap.fs",   32'(fail_seen), 1);
        chk("swap.pass", 32'(pass),      0);

        // restart from DONE with a fixed model
        mode = 0;
        run_sweep(0);
        chk("fix.pass", 32'(pass),    1);
        chk("fix.err",  32'(err_cnt), 0);

        // NOT stuck at 0: vectors 0 and 1 fail
        mode = 2;
        run_sweep(0);
        chk("nst.err",  32'(err_cnt),   2);
        chk("nst.fi",   32'(fail_idx),  0);
        chk("nst.fs",   32'(fail_seen), 1);
        chk("nst.pass", 32'(pass),      0);

        // reset in cycle 5 of a failing sweep
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("abort.err4", 32'(err_cnt),   1);
        chk("abort.ab4",  32'({a_o, b_o}), 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("abort");
        mode = 0;
        tick(1);
        run_sweep(0);
        chk("post.pass", 32'(pass), 1);

        // SETTLE=0: one cycle per vector, done at cycle 5
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("s0.ab@%0d", c),   32'({a0_o, b0_o}), 32'((c <= 4) ? c - 1 : 3));
            chk($sformatf("s0.done@%0d", c), 32'(done0),        32'(c == 5));
            chk($sformatf("s0.busy@%0d", c), 32'(busy0),        32'(c <= 4));
            if (c < 5) tick(1);
        end
        chk("s0.pass", 32'(pass0),    1);
        chk("s0.err",  32'(err_cnt0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
